muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS CPU core. It accepts MULT/MULTU/DIV/DIVU from the ALU decode stage and runs a 32-step shift-add or restoring-divide datapath. It reports busy and done, and stalls MFHI/MFLO reads until the result is valid. It also services MTHI/MTLO writes.

---
 rtl/muldiv_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
//
// Runs MULT/MULTU (32-step shift-add) and DIV/DIVU (32-step restoring
// divide) on latched operands; services MTHI/MTLO while idle and stalls
// MFHI/MFLO reads while an operation is in flight.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, op       : begin operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa, opb        : rs / rt operands, latched when start is taken
//   mthi, mtlo      : write wdata to HI / LO (honoured only while idle)
//   wdata           : MTHI/MTLO data
//   rd_req          : MFHI/MFLO in decode
//   hi, lo          : HI / LO registers
//   busy            : state is not IDLE
//   done            : one-cycle pulse when HI/LO take a new result
//   stall           : rd_req & busy
//
// Build option: define MULDIV_EARLY_EXIT_EN to finish a zero-operand
// multiply or a zero-divisor divide directly from PREP.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] dsr;       // multiplicand magnitude or divisor magnitude
  logic [31:0] acc;       // product high half or partial remainder
  logic [31:0] work;      // multiplier/product low half or dividend/quotient
  logic [4:0]  cnt;
  logic        neg_res, neg_rem;

  logic        is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix;
  logic        res_we;
  logic [31:0] res_hi, res_lo;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign abs_a     = (is_signed && a_q[31]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[31]) ? -b_q : b_q;

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the 64-bit {acc, work} right by one.
  assign mul_sum   = {1'b0, acc} + (work[0] ? {1'b0, dsr} : 33'd0);

  // Divide step: bit 32 of the difference is the borrow (restore needed).
  assign div_shift = {acc, work[31]};
  assign div_diff  = div_shift - {1'b0, dsr};

  assign prod      = {acc, work};
  assign prod_fix  = (is_signed && neg_res) ? -prod : prod;
  assign q_fix     = (is_signed && neg_res) ? -work : work;
  assign r_fix     = (is_signed && neg_rem) ? -acc : acc;

  assign busy  = (state != IDLE);
  assign stall = rd_req & busy;

  always_comb begin
    state_next = state;
    res_we     = 1'b0;
    res_hi     = '0;
    res_lo     = '0;
    case (state)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        state_next = ITER;
`ifdef MULDIV_EARLY_EXIT_EN
        if (is_div ? (b_q == '0) : ((a_q == '0) || (b_q == '0))) begin
          state_next = IDLE;
          res_we     = 1'b1;
          res_hi     = is_div ? a_q : '0;
          res_lo     = is_div ? '1  : '0;
        end
`endif
      end
      ITER: if (cnt == '0) state_next = FIX;
      FIX: begin
        state_next = IDLE;
        res_we     = 1'b1;
        if (is_div) begin
          // Zero divisor bypasses the sign fix and reports opa untouched.
          if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
          end else begin
            res_hi = r_fix;
            res_lo = q_fix;
          end
        end else begin
          res_hi = prod_fix[63:32];
          res_lo = prod_fix[31:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dsr     <= '0;
      acc     <= '0;
      work    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      state <= state_next;
      done  <= res_we;

      if (res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= opa;
            b_q  <= opb;
          end
        end
        PREP: begin
          neg_res <= a_q[31] ^ b_q[31];
          neg_rem <= a_q[31];
          acc     <= '0;
          cnt     <= 5'd31;
          dsr     <= is_div ? abs_b : abs_a;
          work    <= is_div ? abs_a : abs_b;
        end
        ITER: begin
          if (is_div) begin
            if (!div_diff[32]) begin
              acc  <= div_diff[31:0];
              work <= {work[30:0], 1'b1};
            end else begin
              acc  <= div_shift[31:0];
              work <= {work[30:0], 1'b0};
            end
          end else begin
            acc  <= mul_sum[32:1];
            work <= {mul_sum[0], work[31:1]};
          end
          if (cnt != '0) cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, rd_req;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_req(rd_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    int ia, ib;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; el = p[31:0];
          p = r; eh = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  function automatic int exp_cycles(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation and waits for done; all sampling at negedge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int cyc, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom; op = 2'($urandom);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    rh = hi; rl = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; mthi = 0; mtlo = 0; rd_req = 0;
    op = 0; opa = 0; opb = 0; wdata = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hi, lo, busy, done} !== 66'b0)
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b required all zero", hi, lo, busy, done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  vo [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] va [6] = '{32'hFEDC1234, 32'hFEDC1234, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h12345678};
    logic [31:0] vb [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] xh [6] = '{32'hFEDC1233, 32'h0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h12345678};
    logic [31:0] xl [6] = '{32'h0123EDCC, 32'h0123EDCC, 32'hFFFFFFFD, 32'hE, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] rh, rl;
    int cyc, bcnt;
    for (int i = 0; i < 6; i++) begin
      do_op(vo[i], va[i], vb[i], rh, rl, cyc, bcnt);
      n_checks++;
      if (rh !== xh[i] || rl !== xl[i])
        $display("FAIL directed_%0d result: hi=%h lo=%h required hi=%h lo=%h", i, rh, rl, xh[i], xl[i]);
      else n_pass++;
      n_checks++;
      if (cyc != exp_cycles(vo[i], va[i], vb[i]) || bcnt != cyc)
        $display("FAIL directed_%0d latency: edges=%0d busy=%0d required %0d", i, cyc, bcnt, exp_cycles(vo[i], va[i], vb[i]));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, rh, rl, eh, el;
    logic [1:0]  o;
    int cyc, bcnt, errs;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom); a = pick(); b = pick();
      model(o, a, b, eh, el);
      do_op(o, a, b, rh, rl, cyc, bcnt);
      n_checks++;
      if (rh !== eh || rl !== el || cyc != exp_cycles(o, a, b)) begin
        $display("FAIL random op=%0d a=%h b=%h: hi=%h lo=%h edges=%0d required hi=%h lo=%h edges=%0d",
                 o, a, b, rh, rl, cyc, eh, el, exp_cycles(o, a, b));
      end else n_pass++;
    end
  endtask

  task automatic test_mthi();
    logic [31:0] eh, el, rh, rl;
    int cyc, bcnt;
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h1234ABCD;
    n_checks++;
    if (hi !== 32'hAAAA5555) $display("FAIL mthi: hi=%h required aaaa5555", hi);
    else n_pass++;
    @(negedge clk);
    mtlo = 1'b0;
    n_checks++;
    if (lo !== 32'h1234ABCD || hi !== 32'hAAAA5555)
      $display("FAIL mtlo: hi=%h lo=%h required aaaa5555 1234abcd", hi, lo);
    else n_pass++;
    // MTHI in the same cycle as start lands first, then the result overwrites it.
    start = 1'b1; op = 2'b11; opa = 32'd1000; opb = 32'd33; mthi = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    n_checks++;
    if (hi !== 32'h5A5A5A5A) $display("FAIL mthi_with_start: hi=%h required 5a5a5a5a", hi);
    else n_pass++;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    model(2'b11, 32'd1000, 32'd33, eh, el);
    rh = hi; rl = lo; bcnt = 0;
    n_checks++;
    if (rh !== eh || rl !== el) $display("FAIL mthi_overwrite: hi=%h lo=%h required %h %h", rh, rl, eh, el);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, eh, el;
    int cyc, stall_errs;
    a = $urandom; b = $urandom | 32'h1;
    model(2'b01, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = a; opb = b; rd_req = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL stall_in_start_cycle: stall=%b required 0", stall);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0;
    cyc = 0; stall_errs = 0;
    while (!done && cyc < 100) begin
      if (cyc == 10) begin
        rd_req = 1'b1; start = 1'b1; mtlo = 1'b1; mthi = 1'b1;
        wdata = 32'hDEADBEEF; opa = $urandom; opb = $urandom; op = 2'b10;
        #1;
      end
      if (cyc == 11) begin start = 1'b0; mtlo = 1'b0; mthi = 1'b0; end
      if (cyc >= 10 && stall !== 1'b1) stall_errs++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (stall_errs != 0 || cyc != 34)
      $display("FAIL stall_while_busy: bad_cycles=%0d edges=%0d required 0 and 34", stall_errs, cyc);
    else n_pass++;
    n_checks++;
    if (stall !== 1'b0 || hi !== eh || lo !== el)
      $display("FAIL ignore_while_busy: stall=%b hi=%h lo=%h required 0 %h %h", stall, hi, lo, eh, el);
    else n_pass++;
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL dropped_start: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFD; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    start = 1'b1; op = 2'b10; opa = 32'hFFFF_FF9C; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL back_to_back_accept: busy=%b required 1", busy);
    else n_pass++;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    model(2'b10, 32'hFFFF_FF9C, 32'd7, eh, el);
    n_checks++;
    if (hi !== eh || lo !== el || cyc != 34)
      $display("FAIL back_to_back_result: hi=%h lo=%h edges=%0d required %h %h 34", hi, lo, cyc, eh, el);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 32'h1234_5678; opb = 32'h9ABC_DEF1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({hi, lo, busy, done} !== 66'b0)
      $display("FAIL reset_mid_iter: hi=%h lo=%h busy=%b done=%b required all zero", hi, lo, busy, done);
    else n_pass++;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done || busy) dones++; end
    n_checks++;
    if (dones != 0) $display("FAIL reset_no_done: activity_cycles=%0d required 0", dones);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
